multicycle_control: RTL

- Multicycle sequencer for the single-issue MIPS datapath (shared ALU, unified instruction/data memory, IR, A/B/ALUOut registers).
- Decodes opcode from the IR and steps the datapath through fetch/decode/execute/memory/writeback one state per cycle.
- Waits on a memory ready handshake and counts retired instructions.
- Supported opcodes: R-type (and/or/add/sub/slt), addi, andi, lw, sw, beq, j. Anything else is illegal.

---
 rtl/mips_defs_pkg.sv | 65 ++++++
 rtl/mc_output_decode.sv | 83 ++++++++
 rtl/multicycle_control.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mips_defs_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU/mux
// selects, sequencer states and the packed control word.
package mips_defs;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_ADDI  = 3'b011;
  localparam logic [2:0] ALU_ANDI  = 3'b100;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_is_legal(input logic [5:0] op, input logic [5:0] rtype);
    return (op == rtype) || (op == OPC_ADDI) || (op == OPC_ANDI) || (op == OPC_LW) ||
           (op == OPC_SW) || (op == OPC_BEQ) || (op == OPC_J);
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state -> control word decode. Moore outputs except the
// mem_ready gating of ir_write/pc_write in FETCH and the DECODE illegal pulse.
module mc_output_decode
  import mips_defs::*;
#(
  parameter logic [5:0] OP_RTYPE = OPC_RTYPE
) (
  input  logic       rst_i,
  input  state_t     state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] op_latched_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    if (!rst_i) begin
      case (state_i)
        S_FETCH: begin
          ctrl_o.mem_read  = 1'b1;
          ctrl_o.alu_src_b = SRCB_4;
          ctrl_o.alu_op    = ALU_ADD;
          ctrl_o.pc_source = PCSRC_ALU;
          ctrl_o.ir_write  = mem_ready_i;
          ctrl_o.pc_write  = mem_ready_i;
        end
        S_DECODE: begin
          ctrl_o.alu_src_b = SRCB_BR;
          ctrl_o.alu_op    = ALU_ADD;
          ctrl_o.illegal   = !op_is_legal(opcode_i, OP_RTYPE);
        end
        S_MEMADR: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = SRCB_IMM;
          ctrl_o.alu_op    = ALU_ADD;
        end
        S_MEMRD: begin
          ctrl_o.mem_read = 1'b1;
          ctrl_o.i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          ctrl_o.mem_write = 1'b1;
          ctrl_o.i_or_d    = 1'b1;
        end
        S_EXEC: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = SRCB_B;
          ctrl_o.alu_op    = ALU_FUNCT;
        end
        S_RWB: begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.reg_dst   = 1'b1;
        end
        S_IEXEC: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = SRCB_IMM;
          ctrl_o.alu_op    = (op_latched_i == OPC_ANDI) ? ALU_ANDI : ALU_ADDI;
        end
        S_IWB: begin
          ctrl_o.reg_write = 1'b1;
        end
        S_BRANCH: begin
          ctrl_o.alu_src_a     = 1'b1;
          ctrl_o.alu_src_b     = SRCB_B;
          ctrl_o.alu_op        = ALU_SUB;
          ctrl_o.pc_write_cond = 1'b1;
          ctrl_o.pc_source     = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          ctrl_o.pc_write  = 1'b1;
          ctrl_o.pc_source = PCSRC_JUMP;
        end
        default: ctrl_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer: state register, opcode latch, retired counter.
// state | meaning
// 0  FETCH  | read instr at PC, PC+4; wait mem_ready
// 1  DECODE | latch opcode, precompute branch target
// 2  MEMADR | ALUOut = A + imm
// 3  MEMRD  | load data read; wait mem_ready
// 4  MEMWB  | rt <= MDR
// 5  MEMWR  | store write; wait mem_ready
// 6  EXEC   | R-type ALU op
// 7  RWB    | rd <= ALUOut
// 8  BRANCH | beq compare, conditional PC load
// 9  JUMP   | PC <= jump target
// 10 IEXEC  | addi/andi ALU op
// 11 IWB    | rt <= ALUOut
module multicycle_control
  import mips_defs::*;
#(
  parameter int         CNT_W    = 32,
  parameter logic [5:0] OP_RTYPE = 6'b000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  ctrl_t            ctrl;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d = opcode;
        if (opcode == OP_RTYPE)                          state_d = S_EXEC;
        else if (opcode == OPC_LW || opcode == OPC_SW)   state_d = S_MEMADR;
        else if (opcode == OPC_ADDI || opcode == OPC_ANDI) state_d = S_IEXEC;
        else if (opcode == OPC_BEQ)                      state_d = S_BRANCH;
        else if (opcode == OPC_J)                        state_d = S_JUMP;
        else                                             state_d = S_FETCH;
      end
      S_MEMADR: state_d = (op_q == OPC_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC:   state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_q + CNT_W'(retire);
    end
  end

  mc_output_decode #(
    .OP_RTYPE(OP_RTYPE)
  ) u_decode (
    .rst_i       (rst),
    .state_i     (state_q),
    .opcode_i    (opcode),
    .op_latched_i(op_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal       = ctrl.illegal;
  assign state         = state_q;
  assign retired       = retired_q;

endmodule
